// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the bus-CPU memory controller.
// mem_size_t encodes access width; mem_ctrl_state_t is the controller FSM state.
package mips_bus_pkg;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'd0,
      SIZE_HALF = 2'd1,
      SIZE_WORD = 2'd2
   } mem_size_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } mem_ctrl_state_t;

   localparam logic [3:0] BE_NONE    = 4'b0000;
   localparam logic [3:0] BE_BYTE0   = 4'b0001;
   localparam logic [3:0] BE_HALF_LO = 4'b0011;
   localparam logic [3:0] BE_HALF_HI = 4'b1100;
   localparam logic [3:0] BE_WORD    = 4'b1111;

   // The raw size code 3 has no dedicated meaning and behaves as a word access.
   function automatic mem_size_t decode_size(input logic [1:0] raw);
      case (raw)
         2'd0:    return SIZE_BYTE;
         2'd1:    return SIZE_HALF;
         default: return SIZE_WORD;
      endcase
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: byteenable/writedata generation for stores and
// extraction plus sign/zero extension for loads. Purely combinational.
module mem_lane_align
   import mips_bus_pkg::*;
(
   input  mem_size_t   size,
   input  logic [1:0]  offset,
   input  logic [31:0] store_data,
   input  logic [31:0] bus_rdata,
   input  logic        is_signed,
   output logic [3:0]  byteenable,
   output logic [31:0] writedata,
   output logic [31:0] load_data
);

   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   assign sel_byte = bus_rdata[{offset, 3'b000} +: 8];
   assign sel_half = offset[1] ? bus_rdata[31:16] : bus_rdata[15:0];

   // Misaligned half/word offsets are folded down to the containing lane group.
   always_comb begin
      byteenable = BE_NONE;
      writedata  = '0;
      load_data  = '0;
      case (size)
         SIZE_BYTE: begin
            byteenable = BE_BYTE0 << offset;
            writedata  = {4{store_data[7:0]}};
            load_data  = is_signed ? {{24{sel_byte[7]}}, sel_byte}
                                   : {24'b0, sel_byte};
         end
         SIZE_HALF: begin
            byteenable = offset[1] ? BE_HALF_HI : BE_HALF_LO;
            writedata  = {2{store_data[15:0]}};
            load_data  = is_signed ? {{16{sel_half[15]}}, sel_half}
                                   : {16'b0, sel_half};
         end
         default: begin
            byteenable = BE_WORD;
            writedata  = store_data;
            load_data  = bus_rdata;
         end
      endcase
   end

endmodule

// File: rtl/mips_bus_mem_ctrl.sv
// Avalon-MM master sequencer for the multicycle bus CPU: one fetch/load/store at a time.
// Optional build macro MEM_CTRL_ALIGN_CHECK_EN faults misaligned half/word requests in IDLE.
module mips_bus_mem_ctrl
   import mips_bus_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        busy,
   output logic        done,
   output logic        fault,
   output logic [31:0] rdata,
   output logic [31:0] address,
   output logic        read,
   output logic        write,
   input  logic        waitrequest,
   output logic [31:0] writedata,
   output logic [3:0]  byteenable,
   input  logic [31:0] readdata
);

   localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
   localparam logic        TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);

   mem_ctrl_state_t state_q, state_d;
   mem_size_t       size_q, size_d;
   logic            write_q, write_d;
   logic            signed_q, signed_d;
   logic [31:0]     addr_q, addr_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [31:0]     rdata_q, rdata_d;
   logic            fault_q, fault_d;
   logic [31:0]     wait_cnt_q, wait_cnt_d;

   mem_size_t       req_size_dec;
   logic            req_misaligned;
   logic [3:0]      lane_be;
   logic [31:0]     lane_wdata;
   logic [31:0]     lane_load;

   assign req_size_dec = decode_size(req_size);

`ifdef MEM_CTRL_ALIGN_CHECK_EN
   assign req_misaligned = ((req_size_dec == SIZE_HALF) && req_addr[0]) ||
                           ((req_size_dec == SIZE_WORD) && (req_addr[1:0] != 2'b00));
`else
   assign req_misaligned = 1'b0;
`endif

   mem_lane_align u_lane (
      .size       (size_q),
      .offset     (addr_q[1:0]),
      .store_data (wdata_q),
      .bus_rdata  (readdata),
      .is_signed  (signed_q),
      .byteenable (lane_be),
      .writedata  (lane_wdata),
      .load_data  (lane_load)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         size_q     <= SIZE_BYTE;
         write_q    <= 1'b0;
         signed_q   <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         fault_q    <= 1'b0;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         size_q     <= size_d;
         write_q    <= write_d;
         signed_q   <= signed_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         fault_q    <= fault_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      size_d     = size_q;
      write_d    = write_q;
      signed_d   = signed_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      fault_d    = fault_q;
      wait_cnt_d = wait_cnt_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               size_d     = req_size_dec;
               write_d    = req_write;
               signed_d   = req_signed;
               addr_d     = req_addr;
               wdata_d    = req_wdata;
               wait_cnt_d = '0;
               fault_d    = req_misaligned;
               state_d    = req_misaligned ? RESP : ACCESS;
            end
         end
         ACCESS: begin
            if (waitrequest) begin
               // Timeout fires on the last permitted wait cycle; rdata is left untouched.
               if (TIMEOUT_EN && (wait_cnt_q == TIMEOUT_LAST)) begin
                  fault_d = 1'b1;
                  state_d = RESP;
               end else begin
                  wait_cnt_d = wait_cnt_q + 32'd1;
               end
            end else begin
               if (!write_q) begin
                  rdata_d = lane_load;
               end
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      busy       = (state_q != IDLE);
      done       = (state_q == RESP);
      fault      = (state_q == RESP) && fault_q;
      rdata      = rdata_q;
      read       = 1'b0;
      write      = 1'b0;
      address    = '0;
      byteenable = BE_NONE;
      writedata  = '0;
      if (state_q == ACCESS) begin
         read       = !write_q;
         write      = write_q;
         address    = {addr_q[31:2], 2'b00};
         byteenable = lane_be;
         writedata  = lane_wdata;
      end
   end

endmodule
